// File: rtl/apb_master.sv
// apb_master: single-slave APB initiator.
// Turns a valid/ready command into one APB SETUP/ACCESS transfer and returns
// exactly one response per command. Only one transfer is ever outstanding.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that
// wait longer than TIMEOUT_CYCLES for PREADY. An aborted transfer responds
// with rsp_error=1. Without the macro, ACCESS waits for PREADY indefinitely.
// Every output is either a register or a decode of the state register, so
// no input reaches an output in the same cycle.

module apb_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSELx,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic [31:0] r_rdata;
    logic        w_timeout;

    // State register; reset drops any in-flight transfer without a response.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic plus the bus/handshake strobes decoded from the state.
    always_comb begin
        w_nextState = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        PSELx       = 1'b0;
        PENABLE     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_nextState = SETUP;
            end
            SETUP: begin
                PSELx       = 1'b1;
                w_nextState = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || w_timeout) w_nextState = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Capture the command on acceptance and hold it until the next one, so
    // PADDR/PWDATA/PWRITE are stable across SETUP, ACCESS and idle time.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            r_paddr  <= 32'h0;
            r_pwdata <= 32'h0;
            r_pwrite <= 1'b0;
        end else if (r_state == IDLE && cmd_valid) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_write ? cmd_wdata : 32'h0;
        end
    end

    // Response data: slave read data on a completed read, zero otherwise.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'h0;
        end else if (r_state == ACCESS) begin
            if (PREADY)         r_rdata <= r_pwrite ? 32'h0 : PRDATA;
            else if (w_timeout) r_rdata <= 32'h0;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_waitCnt;
    logic        r_error;

    // Count ACCESS cycles spent with PREADY low; restart for every transfer.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset)                            r_waitCnt <= 16'h0;
        else if (r_state == SETUP)            r_waitCnt <= 16'h0;
        else if (r_state == ACCESS && !PREADY) r_waitCnt <= r_waitCnt + 16'd1;
    end

    // Expiry on the edge where the count reaches the limit; PREADY wins a tie.
    assign w_timeout = (r_state == ACCESS) && !PREADY &&
                       ((r_waitCnt + 16'd1) == TIMEOUT_LIMIT);

    // Error flag follows the way the ACCESS phase ended.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (PREADY)         r_error <= 1'b0;
            else if (w_timeout) r_error <= 1'b1;
        end
    end

    assign rsp_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign rsp_error = 1'b0;
`endif

    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign rsp_rdata = r_rdata;

endmodule
